tcam_route_writer: RTL and testbench

Control-plane programmer for the route-lookup TCAM: accepts add/delete route commands over a valid/ready handshake and drives the TCAM write port.
- Per command: validates the netmask, computes the prefix length, finds a matching or free slot, then issues one TCAM write.
- Keeps a shadow copy of prefix, netmask and valid bit per slot, so searches never read the TCAM.
- Sits between the management interface and the TCAM; it is the writer for the TCAM's lookup reader.

---
 rtl/tcam_pkg.sv | 32 +++
 rtl/tcam_mask_check.sv | 22 ++
 rtl/tcam_route_writer.sv | 238 +++++++++++++++++++++++
 tb/tb_tcam_route_writer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tcam_pkg.sv
// Shared types and constants for the route-lookup TCAM writer and its bench.
package tcam_pkg;

  localparam int TCAM_WIDTH = 32;
  localparam int TCAM_SIZE  = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_DEL = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_FULL     = 2'd1,
    ST_BADMASK  = 2'd2,
    ST_NOTFOUND = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_SEARCH = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  // Content word layout {if_idx, netmask, prefix}
  localparam int IFIDX_LSB  = 2 * TCAM_WIDTH;
  localparam int MASK_LSB   = TCAM_WIDTH;
  localparam int PREFIX_LSB = 0;

endpackage

// File: rtl/tcam_mask_check.sv
// Combinational netmask checker: contiguous-from-MSB flag and popcount.
module tcam_mask_check #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] mask_i,
  output logic             contig_o,
  output logic [7:0]       plen_o
);

  logic [WIDTH-1:0] inv_s;

  // A mask of leading ones has an inverse of trailing ones, so inv & (inv+1) is zero.
  always_comb begin
    inv_s    = ~mask_i;
    contig_o = ((inv_s & (inv_s + {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});
    plen_o   = 8'd0;
    for (int i = 0; i < WIDTH; i++) begin
      plen_o = plen_o + {7'd0, mask_i[i]};
    end
  end

endmodule

// File: rtl/tcam_route_writer.sv
// Route-table programmer driving the TCAM write port from add/delete commands.
// Optional TCAM_WR_MASK_NORMALIZE_EN: clear host bits instead of rejecting them.
module tcam_route_writer
  import tcam_pkg::*;
#(
  parameter int WIDTH = TCAM_WIDTH,
  parameter int SIZE  = TCAM_SIZE,
  parameter int SLOTW = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_op,
  input  logic [WIDTH-1:0]     cmd_prefix,
  input  logic [WIDTH-1:0]     cmd_netmask,
  input  logic [3:0]           cmd_if_idx,
  input  logic [WIDTH-1:0]     cmd_next_hop,
  output logic                 resp_valid,
  output logic [1:0]           resp_status,
  output logic [SLOTW-1:0]     resp_slot,
  output logic                 tcam_wr_en,
  output logic [SLOTW-1:0]     tcam_wr_slot,
  output logic [2*WIDTH+3:0]   tcam_wr_entry,
  output logic [WIDTH-1:0]     tcam_wr_next_hop,
  output logic [7:0]           tcam_wr_plen,
  output logic                 tcam_wr_valid,
  output logic [SLOTW:0]       occupancy
);

  localparam logic [SLOTW-1:0] LAST_SLOT = SLOTW'(SIZE - 1);

  state_e             state_q, state_d;
  status_e            status_q, status_d;
  logic [SLOTW-1:0]   slot_q, slot_d;
  op_e                op_q;
  logic [WIDTH-1:0]   prefix_q, mask_q, next_hop_q;
  logic [3:0]         if_idx_q;
  logic [7:0]         plen_q;
  logic [SLOTW-1:0]   idx_q, hit_slot_q, free_slot_q;
  logic               hit_q, free_q;

  logic [WIDTH-1:0]   sh_prefix_q [SIZE];
  logic [WIDTH-1:0]   sh_mask_q   [SIZE];
  logic [SIZE-1:0]    sh_valid_q;
  logic [SLOTW:0]     occ_q;

  logic               wr_en_q, wr_valid_q, resp_valid_q;
  logic [SLOTW-1:0]   wr_slot_q, resp_slot_q;
  logic [2*WIDTH+3:0] wr_entry_q;
  logic [WIDTH-1:0]   wr_nh_q;
  logic [7:0]         wr_plen_q;
  logic [1:0]         resp_status_q;

  logic               contig_s, bad_s, match_s, hit_any_s, free_any_s;
  logic [7:0]         plen_s;
  logic [SLOTW-1:0]   hit_slot_s, free_slot_s;

  tcam_mask_check #(.WIDTH(WIDTH)) u_mask_check (
    .mask_i   (mask_q),
    .contig_o (contig_s),
    .plen_o   (plen_s)
  );

  assign cmd_ready        = (state_q == S_IDLE) && !rst;
  assign resp_valid       = resp_valid_q;
  assign resp_status      = resp_status_q;
  assign resp_slot        = resp_slot_q;
  assign tcam_wr_en       = wr_en_q;
  assign tcam_wr_slot     = wr_slot_q;
  assign tcam_wr_entry    = wr_entry_q;
  assign tcam_wr_next_hop = wr_nh_q;
  assign tcam_wr_plen     = wr_plen_q;
  assign tcam_wr_valid    = wr_valid_q;
  assign occupancy        = occ_q;

  // Next-state logic; the last search cycle folds in the final slot's compare.
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    slot_d      = slot_q;
`ifdef TCAM_WR_MASK_NORMALIZE_EN
    bad_s       = !contig_s;
`else
    bad_s       = !contig_s || ((prefix_q & ~mask_q) != {WIDTH{1'b0}});
`endif
    match_s     = sh_valid_q[idx_q] && (sh_prefix_q[idx_q] == prefix_q) &&
                  (sh_mask_q[idx_q] == mask_q);
    hit_any_s   = hit_q || match_s;
    hit_slot_s  = hit_q ? hit_slot_q : idx_q;
    free_any_s  = free_q || !sh_valid_q[idx_q];
    free_slot_s = free_q ? free_slot_q : idx_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) state_d = S_CHECK;
        else           state_d = S_IDLE;
      end
      S_CHECK: begin
        if (bad_s) begin
          state_d  = S_RESP;
          status_d = ST_BADMASK;
          slot_d   = {SLOTW{1'b0}};
        end else begin
          state_d  = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (idx_q != LAST_SLOT) begin
          state_d = S_SEARCH;
        end else if (hit_any_s) begin
          state_d  = S_WRITE;
          status_d = ST_OK;
          slot_d   = hit_slot_s;
        end else if ((op_q == OP_ADD) && free_any_s) begin
          state_d  = S_WRITE;
          status_d = ST_OK;
          slot_d   = free_slot_s;
        end else begin
          state_d  = S_RESP;
          status_d = (op_q == OP_ADD) ? ST_FULL : ST_NOTFOUND;
          slot_d   = {SLOTW{1'b0}};
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
      slot_q   <= {SLOTW{1'b0}};
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      slot_q   <= slot_d;
    end
  end

  // Command capture and search bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= OP_ADD;
      prefix_q    <= {WIDTH{1'b0}};
      mask_q      <= {WIDTH{1'b0}};
      next_hop_q  <= {WIDTH{1'b0}};
      if_idx_q    <= 4'd0;
      plen_q      <= 8'd0;
      idx_q       <= {SLOTW{1'b0}};
      hit_q       <= 1'b0;
      hit_slot_q  <= {SLOTW{1'b0}};
      free_q      <= 1'b0;
      free_slot_q <= {SLOTW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q       <= op_e'(cmd_op);
            prefix_q   <= cmd_prefix;
            mask_q     <= cmd_netmask;
            next_hop_q <= cmd_next_hop;
            if_idx_q   <= cmd_if_idx;
          end
        end
        S_CHECK: begin
`ifdef TCAM_WR_MASK_NORMALIZE_EN
          prefix_q <= prefix_q & mask_q;
`endif
          plen_q <= plen_s;
          idx_q  <= {SLOTW{1'b0}};
          hit_q  <= 1'b0;
          free_q <= 1'b0;
        end
        S_SEARCH: begin
          idx_q       <= idx_q + {{(SLOTW-1){1'b0}}, 1'b1};
          hit_q       <= hit_any_s;
          hit_slot_q  <= hit_slot_s;
          free_q      <= free_any_s;
          free_slot_q <= free_slot_s;
        end
        default: ;
      endcase
    end
  end

  // Registered TCAM write port and response, launched from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q       <= 1'b0;
      wr_slot_q     <= {SLOTW{1'b0}};
      wr_entry_q    <= {(2*WIDTH+4){1'b0}};
      wr_nh_q       <= {WIDTH{1'b0}};
      wr_plen_q     <= 8'd0;
      wr_valid_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= 2'd0;
      resp_slot_q   <= {SLOTW{1'b0}};
    end else begin
      wr_en_q    <= (state_d == S_WRITE);
      wr_slot_q  <= (state_d == S_WRITE) ? slot_d : {SLOTW{1'b0}};
      if ((state_d == S_WRITE) && (op_q == OP_ADD)) begin
        wr_entry_q <= {if_idx_q, mask_q, prefix_q};
        wr_nh_q    <= next_hop_q;
        wr_plen_q  <= plen_q;
        wr_valid_q <= 1'b1;
      end else begin
        wr_entry_q <= {(2*WIDTH+4){1'b0}};
        wr_nh_q    <= {WIDTH{1'b0}};
        wr_plen_q  <= 8'd0;
        wr_valid_q <= 1'b0;
      end
      resp_valid_q  <= (state_d == S_RESP);
      resp_status_q <= (state_d == S_RESP) ? status_d : 2'd0;
      resp_slot_q   <= (state_d == S_RESP) ? slot_d : {SLOTW{1'b0}};
    end
  end

  // Shadow table and occupancy follow the write port on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        sh_prefix_q[i] <= {WIDTH{1'b0}};
        sh_mask_q[i]   <= {WIDTH{1'b0}};
      end
      sh_valid_q <= {SIZE{1'b0}};
      occ_q      <= {(SLOTW+1){1'b0}};
    end else if (wr_en_q) begin
      sh_prefix_q[wr_slot_q] <= wr_entry_q[WIDTH-1:0];
      sh_mask_q[wr_slot_q]   <= wr_entry_q[2*WIDTH-1:WIDTH];
      sh_valid_q[wr_slot_q]  <= wr_valid_q;
      occ_q <= occ_q - {{SLOTW{1'b0}}, sh_valid_q[wr_slot_q]} + {{SLOTW{1'b0}}, wr_valid_q};
    end
  end

endmodule

// File: tb/tb_tcam_route_writer.sv
// Directed self-checking bench for tcam_route_writer (SIZE=8, WIDTH=32).
module tb_tcam_route_writer;
  import tcam_pkg::*;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [W-1:0]  cmd_prefix, cmd_netmask, cmd_next_hop;
  logic [3:0]    cmd_if_idx;
  logic          resp_valid;
  logic [1:0]    resp_status;
  logic [SW-1:0] resp_slot;
  logic          tcam_wr_en;
  logic [SW-1:0] tcam_wr_slot;
  logic [2*W+3:0] tcam_wr_entry;
  logic [W-1:0]  tcam_wr_next_hop;
  logic [7:0]    tcam_wr_plen;
  logic          tcam_wr_valid;
  logic [SW:0]   occupancy;

  tcam_route_writer #(.WIDTH(W), .SIZE(N)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_prefix(cmd_prefix), .cmd_netmask(cmd_netmask),
    .cmd_if_idx(cmd_if_idx), .cmd_next_hop(cmd_next_hop),
    .resp_valid(resp_valid), .resp_status(resp_status), .resp_slot(resp_slot),
    .tcam_wr_en(tcam_wr_en), .tcam_wr_slot(tcam_wr_slot),
    .tcam_wr_entry(tcam_wr_entry), .tcam_wr_next_hop(tcam_wr_next_hop),
    .tcam_wr_plen(tcam_wr_plen), .tcam_wr_valid(tcam_wr_valid),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int            lat, wr_cnt, got;
  logic [SW-1:0] c_wslot, c_rslot;
  logic [2*W+3:0] c_entry;
  logic [W-1:0]  c_nh;
  logic [7:0]    c_plen;
  logic          c_wvalid;
  logic [1:0]    c_status;

  task automatic check(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic send(input string tag, input logic op, input logic [W-1:0] pfx,
                      input logic [W-1:0] msk, input logic [3:0] ifi, input logic [W-1:0] nh);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_prefix = pfx; cmd_netmask = msk;
    cmd_if_idx = ifi; cmd_next_hop = nh;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0; wr_cnt = 0; got = 0;
    c_wslot = '0; c_entry = '0; c_nh = '0; c_plen = '0; c_wvalid = 1'b0;
    c_status = '0; c_rslot = '0;
    while (got == 0 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (tcam_wr_en) begin
        wr_cnt++;
        c_wslot = tcam_wr_slot; c_entry = tcam_wr_entry; c_nh = tcam_wr_next_hop;
        c_plen = tcam_wr_plen; c_wvalid = tcam_wr_valid;
      end
      if (resp_valid) begin
        got = 1;
        c_status = resp_status;
        c_rslot = resp_slot;
      end
    end
    check({tag, "_resp_seen"}, got, 1);
  endtask

  // An accepted write: one strobe, OK status at SIZE+3.
  task automatic expect_ok(input string tag, input int slot, input int occ);
    check({tag, "_lat"}, lat, N + 3);
    check({tag, "_wrcnt"}, wr_cnt, 1);
    check({tag, "_status"}, c_status, ST_OK);
    check({tag, "_rslot"}, c_rslot, slot);
    check({tag, "_wslot"}, c_wslot, slot);
    check({tag, "_occ"}, occupancy, occ);
  endtask

  // A rejected command: no strobe, given status and latency, slot 0.
  task automatic expect_rej(input string tag, input int st, input int l, input int occ);
    check({tag, "_lat"}, lat, l);
    check({tag, "_wrcnt"}, wr_cnt, 0);
    check({tag, "_status"}, c_status, st);
    check({tag, "_rslot"}, c_rslot, 0);
    check({tag, "_occ"}, occupancy, occ);
  endtask

  initial begin
    int bad;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_prefix = '0;
    cmd_netmask = '0; cmd_if_idx = '0; cmd_next_hop = '0;
    #1;
    check("rst_ready", cmd_ready, 0);
    check("rst_occ", occupancy, 0);
    check("rst_wr_en", tcam_wr_en, 0);
    check("rst_resp", resp_valid, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("rel_ready", cmd_ready, 1);

    send("add0", 1'b0, 32'hC0A80000, 32'hFFFFFF00, 4'd2, 32'h0A000001);
    expect_ok("add0", 0, 1);
    check("add0_plen", c_plen, 24);
    check("add0_valid", c_wvalid, 1);
    check("add0_entry", c_entry, {4'd2, 32'hFFFFFF00, 32'hC0A80000});
    check("add0_if", c_entry[IFIDX_LSB +: 4], 4'd2);
    check("add0_nh", c_nh, 32'h0A000001);

    send("readd", 1'b0, 32'hC0A80000, 32'hFFFFFF00, 4'd5, 32'h0A000002);
    expect_ok("readd", 0, 1);
    check("readd_entry", c_entry, {4'd5, 32'hFFFFFF00, 32'hC0A80000});

    for (int i = 1; i < N; i++) begin
      send("fill", 1'b0, 32'hC0A80000 | (i << 8), 32'hFFFFFF00, 4'(i), 32'h0A000000 + i);
      expect_ok("fill", i, i + 1);
      check("fill_pfx", c_entry[PREFIX_LSB +: W], 32'hC0A80000 | (i << 8));
    end
    send("full", 1'b0, 32'hC0A80800, 32'hFFFFFF00, 4'd1, 32'h0A000009);
    expect_rej("full", ST_FULL, N + 2, N);

    send("del_absent", 1'b1, 32'h0A000000, 32'hFF000000, 4'd0, 32'h0);
    expect_rej("del_absent", ST_NOTFOUND, N + 2, N);

    send("del1", 1'b1, 32'hC0A80100, 32'hFFFFFF00, 4'd0, 32'h0);
    expect_ok("del1", 1, N - 1);
    check("del1_valid", c_wvalid, 0);
    check("del1_entry", c_entry, 0);
    send("reuse1", 1'b0, 32'h0A000000, 32'hFF000000, 4'd3, 32'h0B000001);
    expect_ok("reuse1", 1, N);
    check("reuse1_plen", c_plen, 8);
    check("reuse1_mask", c_entry[MASK_LSB +: W], 32'hFF000000);

    send("noncontig", 1'b0, 32'hC0A80000, 32'hFF00FF00, 4'd1, 32'h1);
    expect_rej("noncontig", ST_BADMASK, 2, N);

    send("hostbits", 1'b0, 32'hC0A80001, 32'hFFFFFF00, 4'd7, 32'h2);
`ifdef TCAM_WR_MASK_NORMALIZE_EN
    expect_ok("hostbits", 0, N);
    check("hostbits_entry", c_entry, {4'd7, 32'hFFFFFF00, 32'hC0A80000});
`else
    expect_rej("hostbits", ST_BADMASK, 2, N);
`endif

    // Reset during SEARCH aborts the command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_prefix = 32'hC0A80200; cmd_netmask = 32'hFFFFFF00;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", cmd_ready, 0);
    check("mid_rst_occ", occupancy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("mid_rel_ready", cmd_ready, 1);
    bad = 0;
    for (int i = 0; i < N + 6; i++) begin
      @(negedge clk);
      if (tcam_wr_en || resp_valid) bad++;
    end
    check("mid_rst_quiet", bad, 0);
    check("mid_rst_occ2", occupancy, 0);

    send("dflt", 1'b0, 32'h00000000, 32'h00000000, 4'd9, 32'hC0000001);
    expect_ok("dflt", 0, 1);
    check("dflt_plen", c_plen, 0);
    send("host32", 1'b0, 32'h01020304, 32'hFFFFFFFF, 4'd4, 32'hC0000002);
    expect_ok("host32", 1, 2);
    check("host32_plen", c_plen, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
